// File: rtl/noc_pkg.sv
// Shared flit layout and helpers for the PE <-> NoC leaf interface.
package noc_pkg;

    localparam int unsigned FLIT_W    = 32;
    localparam int unsigned ADDR_MSB  = 31;
    localparam int unsigned ADDR_LSB  = 24;
    localparam int unsigned ADDR_W    = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned PAYLOAD_W = 24;

    // One network flit: destination header on top of the payload.
    typedef struct packed {
        logic [ADDR_W-1:0]    dest;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    function automatic flit_t make_flit(input logic [ADDR_W-1:0] dest,
                                        input logic [PAYLOAD_W-1:0] payload);
        flit_t f;
        f.dest    = dest;
        f.payload = payload;
        return f;
    endfunction

    function automatic logic [ADDR_W-1:0] flit_dest(input flit_t flit);
        return flit.dest;
    endfunction

endpackage

// File: rtl/pe_noc_interface_if.sv
// Handshake/bus bundle between the PE, the NoC switch port and this interface.
interface pe_noc_interface_if;
    import noc_pkg::*;

    // PE transmit side
    logic [PAYLOAD_W-1:0] i_pe_data;
    logic [ADDR_W-1:0]    i_pe_dest;
    logic                 i_pe_valid;
    logic                 o_pe_ready;
    // switch input port (flits leaving the PE)
    logic [FLIT_W-1:0]    o_data;
    logic                 o_data_valid;
    logic                 i_data_ready;
    // switch output port (flits arriving at the PE)
    logic [FLIT_W-1:0]    i_data;
    logic                 i_data_valid;
    logic                 o_data_ready;
    // PE receive side
    logic [PAYLOAD_W-1:0] o_pe_data;
    logic                 o_pe_valid;
    logic                 i_pe_ready;

    // Network interface view
    modport slave (
        input  i_pe_data, i_pe_dest, i_pe_valid,
        output o_pe_ready,
        output o_data, o_data_valid,
        input  i_data_ready,
        input  i_data, i_data_valid,
        output o_data_ready,
        output o_pe_data, o_pe_valid,
        input  i_pe_ready
    );

    // PE + switch environment view
    modport master (
        output i_pe_data, i_pe_dest, i_pe_valid,
        input  o_pe_ready,
        input  o_data, o_data_valid,
        output i_data_ready,
        output i_data, i_data_valid,
        input  o_data_ready,
        input  o_pe_data, o_pe_valid,
        output i_pe_ready
    );

endinterface

// File: rtl/noc_tx_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides; no full bypass.
module noc_tx_fifo #(
    parameter int unsigned Width = 32,
    parameter int unsigned Depth = 4
) (
    input  logic             i_sclk,
    input  logic             i_reset,
    input  logic [Width-1:0] i_wr_data,
    input  logic             i_wr_valid,
    output logic             o_wr_ready,
    output logic [Width-1:0] o_rd_data,
    output logic             o_rd_valid,
    input  logic             i_rd_ready
);

    localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned PW = AW + 1;

    logic [Width-1:0] mem [Depth];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Extra pointer MSB tells a full ring from an empty one.
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_wr_ready = !full && !i_reset;
    assign push       = i_wr_valid && o_wr_ready;
    assign o_rd_valid = !empty;
    assign pop        = o_rd_valid && i_rd_ready;
    assign o_rd_data  = mem[rd_ptr[AW-1:0]];

    // Pointer update; both wrap modulo 2*Depth.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage, cleared so the head reads as zero out of reset.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < int'(Depth); i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

endmodule

// File: rtl/pe_noc_interface.sv
// PE <-> NoC leaf network interface: TX packing FIFO, RX address filter, statistics.
module pe_noc_interface
    import noc_pkg::*;
#(
    parameter int unsigned DataWidth = FLIT_W,
    parameter int unsigned MyAddr    = 0,
    parameter int unsigned TxDepth   = 4,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                i_sclk,
    input  logic                i_reset,
    pe_noc_interface_if.slave   bus,
    output logic [CntWidth-1:0] o_tx_count,
    output logic [CntWidth-1:0] o_rx_count,
    output logic [CntWidth-1:0] o_drop_count
);

    flit_t                tx_flit;
    logic [DataWidth-1:0] fifo_head;
    flit_t                rx_flit;
    logic                 rx_valid;
    logic [PAYLOAD_W-1:0] rx_data;
    logic                 rx_accept;
    logic                 rx_hit;
    logic                 rx_consume;
    logic                 tx_event;
    logic                 drop_event;

    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

    // TX: pack header + payload and queue towards the switch.
    assign tx_flit = make_flit(bus.i_pe_dest, bus.i_pe_data);

    noc_tx_fifo #(
        .Width (DataWidth),
        .Depth (TxDepth)
    ) u_tx_fifo (
        .i_sclk     (i_sclk),
        .i_reset    (i_reset),
        .i_wr_data  (DataWidth'(tx_flit)),
        .i_wr_valid (bus.i_pe_valid),
        .o_wr_ready (bus.o_pe_ready),
        .o_rd_data  (fifo_head),
        .o_rd_valid (bus.o_data_valid),
        .i_rd_ready (bus.i_data_ready)
    );

    assign bus.o_data = FLIT_W'(fifo_head);
    assign tx_event   = bus.o_data_valid && bus.i_data_ready;

    // RX: single-entry skid-free register, refillable while being drained.
    assign rx_flit          = flit_t'(bus.i_data);
    assign bus.o_data_ready = (!rx_valid || bus.i_pe_ready) && !i_reset;
    assign rx_accept        = bus.i_data_valid && bus.o_data_ready;
    assign rx_hit           = (flit_dest(rx_flit) == ADDR_W'(MyAddr));
    assign rx_consume       = rx_valid && bus.i_pe_ready;
    assign drop_event       = rx_accept && !rx_hit;
    assign bus.o_pe_valid   = rx_valid;
    assign bus.o_pe_data    = rx_data;

    // RX output register: reload on a matching flit, otherwise clear on consume.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else if (rx_accept && rx_hit) begin
            rx_valid <= 1'b1;
            rx_data  <= rx_flit.payload;
        end else if (rx_consume) begin
            rx_valid <= 1'b0;
        end
    end

    // Saturating event counters, each updated independently.
    always_ff @(posedge i_sclk or posedge i_reset) begin
        if (i_reset) begin
            o_tx_count   <= '0;
            o_rx_count   <= '0;
            o_drop_count <= '0;
        end else begin
            if (tx_event)   o_tx_count   <= sat_inc(o_tx_count);
            if (rx_consume) o_rx_count   <= sat_inc(o_rx_count);
            if (drop_event) o_drop_count <= sat_inc(o_drop_count);
        end
    end

endmodule

// File: tb/tb_pe_noc_interface.sv
// Randomised + directed bench for pe_noc_interface against a queue-based reference model.
module tb_pe_noc_interface;

    localparam int unsigned MY_ADDR  = 3;
    localparam int          TX_DEPTH = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int          CNT_MAX  = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [CNT_W-1:0] tx_count;
    logic [CNT_W-1:0] rx_count;
    logic [CNT_W-1:0] drop_count;

    pe_noc_interface_if bus();

    pe_noc_interface #(
        .DataWidth (32),
        .MyAddr    (MY_ADDR),
        .TxDepth   (TX_DEPTH),
        .CntWidth  (CNT_W)
    ) dut (
        .i_sclk       (clk),
        .i_reset      (rst),
        .bus          (bus),
        .o_tx_count   (tx_count),
        .o_rx_count   (rx_count),
        .o_drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // reference model state
    logic [31:0] m_q[$];
    bit          m_rxv = 1'b0;
    logic [23:0] m_rxd = '0;
    int          m_tx = 0, m_rx = 0, m_drop = 0;

    // observed transfers
    logic [31:0] tx_seen[$];
    logic [23:0] rx_seen[$];
    int          rx_cyc[$];
    logic        smp_pe_ready;
    logic        smp_data_ready;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_rxv = 1'b0;
        m_rxd = '0;
        m_tx = 0; m_rx = 0; m_drop = 0;
    endtask

    // One clock: drive at negedge, compare against the model, advance the model.
    task automatic step(input bit pv, input logic [7:0] pd, input logic [23:0] pp,
                        input bit dr, input bit dv, input logic [31:0] din, input bit pr,
                        output bit tx_acc, output bit rx_acc);
        bit push, pop, acc, hit, cons;
        @(negedge clk);
        bus.i_pe_valid   = pv;
        bus.i_pe_dest    = pd;
        bus.i_pe_data    = pp;
        bus.i_data_ready = dr;
        bus.i_data_valid = dv;
        bus.i_data       = din;
        bus.i_pe_ready   = pr;
        #1;
        smp_pe_ready   = bus.o_pe_ready;
        smp_data_ready = bus.o_data_ready;
        chk_eq("pe_ready",   32'(bus.o_pe_ready),   32'(m_q.size() < TX_DEPTH));
        chk_eq("data_valid", 32'(bus.o_data_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk_eq("data", bus.o_data, m_q[0]);
        chk_eq("data_ready", 32'(bus.o_data_ready), 32'(!m_rxv || pr));
        chk_eq("pe_valid",   32'(bus.o_pe_valid),   32'(m_rxv));
        if (m_rxv) chk_eq("pe_data", 32'(bus.o_pe_data), 32'(m_rxd));
        chk_eq("tx_count",   32'(tx_count),   32'(m_tx));
        chk_eq("rx_count",   32'(rx_count),   32'(m_rx));
        chk_eq("drop_count", 32'(drop_count), 32'(m_drop));
        if (bus.o_data_valid && dr) tx_seen.push_back(bus.o_data);
        if (bus.o_pe_valid && pr) begin
            rx_seen.push_back(bus.o_pe_data);
            rx_cyc.push_back(cyc);
        end
        push = pv && (m_q.size() < TX_DEPTH);
        pop  = dr && (m_q.size() != 0);
        acc  = dv && (!m_rxv || pr);
        hit  = (din[31:24] == 8'(MY_ADDR));
        cons = m_rxv && pr;
        if (pop) begin
            void'(m_q.pop_front());
            m_tx = sat(m_tx);
        end
        if (push) m_q.push_back({pd, pp});
        if (cons) m_rx = sat(m_rx);
        if (acc && !hit) m_drop = sat(m_drop);
        if (acc && hit) begin
            m_rxv = 1'b1;
            m_rxd = din[23:0];
        end else if (cons) begin
            m_rxv = 1'b0;
        end
        tx_acc = push;
        rx_acc = acc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        bit ta, ra;
        for (int t = 0; t < 20 && (m_q.size() != 0 || m_rxv); t++)
            step(1'b0, 8'h0, 24'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, ra);
        chk_eq(tag, 32'(m_q.size() + int'(m_rxv)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ta, ra, acc;
        int start, pp_n;
        bit pv, dv, dr, pr, pv_hold, dv_hold;
        logic [7:0]  pd;
        logic [23:0] pp;
        logic [31:0] din;

        bus.i_pe_valid = 0; bus.i_pe_dest = 0; bus.i_pe_data = 0;
        bus.i_data_ready = 0; bus.i_data_valid = 0; bus.i_data = 0; bus.i_pe_ready = 0;

        // reset state
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.i_pe_ready = 1'b1;
        #1;
        chk_eq("rst_pe_ready",   32'(bus.o_pe_ready),   32'd0);
        chk_eq("rst_data_ready", 32'(bus.o_data_ready), 32'd0);
        chk_eq("rst_data_valid", 32'(bus.o_data_valid), 32'd0);
        chk_eq("rst_pe_valid",   32'(bus.o_pe_valid),   32'd0);
        chk_eq("rst_data",       bus.o_data,            32'd0);
        chk_eq("rst_pe_data",    32'(bus.o_pe_data),    32'd0);
        chk_eq("rst_counts",     32'({tx_count, rx_count, drop_count}), 32'd0);
        rst = 1'b0;
        model_reset();

        // single TX flit, one-cycle latency
        step(1'b1, 8'h01, 24'h00ABCD, 1'b1, 1'b0, 32'h0, 1'b0, ta, ra);
        chk_eq("t1_valid", 32'(bus.o_data_valid), 32'd1);
        chk_eq("t1_data",  bus.o_data, 32'h0100ABCD);
        step(1'b0, 8'h00, 24'h0, 1'b1, 1'b0, 32'h0, 1'b0, ta, ra);
        chk_eq("t1_tx_count", 32'(tx_count), 32'd1);

        // fill to full with switch stalled, 5th push waits, no loss
        tx_seen.delete();
        for (int k = 0; k < 5; k++) begin
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                step(1'b1, 8'(8'h10 + k), 24'(24'h100 + k), (k == 4 && t > 0),
                     1'b0, 32'h0, 1'b0, ta, ra);
                if (k == 4 && t == 0) chk_eq("t2_full_ready", 32'(smp_pe_ready), 32'd0);
                acc = ta;
            end
            chk_eq("t2_push_bound", 32'(acc), 32'd1);
        end
        drain("t2_drain_bound");
        chk_eq("t2_out_count", 32'(tx_seen.size()), 32'd5);
        for (int k = 0; k < 5 && k < tx_seen.size(); k++)
            chk_eq("t2_out_order", tx_seen[k], {8'(8'h10 + k), 24'(24'h100 + k)});

        // RX match then misrouted flit
        rx_seen.delete(); rx_cyc.delete();
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b1, 32'h03123456, 1'b1, ta, ra);
        chk_eq("t3_pe_valid", 32'(bus.o_pe_valid), 32'd1);
        chk_eq("t3_pe_data",  32'(bus.o_pe_data),  32'h123456);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b1, 32'h07FFFFFF, 1'b1, ta, ra);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, ra);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, ra);
        chk_eq("t3_deliveries", 32'(rx_seen.size()), 32'd1);
        if (rx_seen.size() > 0) chk_eq("t3_payload", 32'(rx_seen[0]), 32'h123456);
        chk_eq("t3_rx_count",   32'(rx_count),   32'd1);
        chk_eq("t3_drop_count", 32'(drop_count), 32'd1);

        // RX backpressure then back-to-back delivery
        rx_seen.delete(); rx_cyc.delete();
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b1, 32'h03000001, 1'b0, ta, ra);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b1, 32'h03000002, 1'b0, ta, ra);
        chk_eq("t4_full_ready", 32'(smp_data_ready), 32'd0);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b1, 32'h03000002, 1'b1, ta, ra);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b1, 32'h03000003, 1'b1, ta, ra);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, ra);
        step(1'b0, 8'h0, 24'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, ra);
        chk_eq("t4_deliveries", 32'(rx_seen.size()), 32'd3);
        for (int k = 0; k < 3 && k < rx_seen.size(); k++)
            chk_eq("t4_payload", 32'(rx_seen[k]), 32'(k + 1));
        if (rx_cyc.size() == 3) chk_eq("t4_b2b", 32'(rx_cyc[2] - rx_cyc[0]), 32'd2);

        // TX counter saturation
        start = tx_seen.size();
        pp_n  = 0;
        for (int t = 0; t < 80 && (tx_seen.size() - start) < 20; t++) begin
            step(1'b1, 8'h05, 24'(pp_n), 1'b1, 1'b0, 32'h0, 1'b1, ta, ra);
            if (ta) pp_n++;
        end
        chk_eq("t5_pop_bound", 32'((tx_seen.size() - start) >= 20), 32'd1);
        drain("t5_drain_bound");
        chk_eq("t5_tx_sat", 32'(tx_count), 32'hF);

        // asynchronous reset mid-stream
        step(1'b1, 8'h21, 24'h000001, 1'b0, 1'b1, 32'h03CAFE01, 1'b0, ta, ra);
        step(1'b1, 8'h22, 24'h000002, 1'b0, 1'b0, 32'h0, 1'b0, ta, ra);
        step(1'b1, 8'h23, 24'h000003, 1'b0, 1'b0, 32'h0, 1'b0, ta, ra);
        @(negedge clk);
        bus.i_pe_valid = 1'b0; bus.i_data_valid = 1'b0; bus.i_data_ready = 1'b0;
        bus.i_pe_ready = 1'b1;
        #1;
        chk_eq("t6_pre_data_valid", 32'(bus.o_data_valid), 32'd1);
        chk_eq("t6_pre_data_ready", 32'(bus.o_data_ready), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk_eq("t6_data_valid", 32'(bus.o_data_valid), 32'd0);
        chk_eq("t6_pe_valid",   32'(bus.o_pe_valid),   32'd0);
        chk_eq("t6_pe_ready",   32'(bus.o_pe_ready),   32'd0);
        chk_eq("t6_data_ready", 32'(bus.o_data_ready), 32'd0);
        chk_eq("t6_data",       bus.o_data,            32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 8'h0, 24'h0, 1'b0, 1'b0, 32'h0, 1'b0, ta, ra);
        chk_eq("t6_empty",  32'(bus.o_data_valid), 32'd0);
        chk_eq("t6_counts", 32'({tx_count, rx_count, drop_count}), 32'd0);

        // randomised traffic on both paths, sources hold until transfer
        pv_hold = 1'b0; dv_hold = 1'b0;
        pv = 0; pd = 0; pp = 0; dv = 0; din = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pv_hold) begin
                pv = ($urandom_range(0, 3) != 0);
                pd = 8'($urandom);
                pp = 24'($urandom);
            end
            if (!dv_hold) begin
                dv  = ($urandom_range(0, 3) != 0);
                din = {(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'(MY_ADDR)), 24'($urandom)};
            end
            dr = ($urandom_range(0, 9) < 2 + 3 * (i / 100));
            pr = ($urandom_range(0, 9) < 9 - 3 * (i / 100));
            step(pv, pd, pp, dr, dv, din, pr, ta, ra);
            pv_hold = pv && !ta;
            dv_hold = dv && !ra;
        end
        drain("rand_drain_bound");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
